// File: rtl/qspi_flash_ctrl_if.sv
// Request / read-data channel between the SoC bus adapter and qspi_flash_ctrl.
// The master side issues read requests; the slave side is the flash controller.
interface qspi_flash_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready, rd_data, rd_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/qspi_flash_ctrl.sv
// Host-side SPI/QSPI flash read controller (mode 0). Single-wire read (0x03) by default;
// define QSPI_QUAD_READ_EN for quad output fast read (0x6B, 8 dummy cycles, 4-bit data).
module qspi_flash_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  qspi_flash_ctrl_if.slave  bus,
  output logic              sck,
  output logic              cs_n,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);

`ifdef QSPI_QUAD_READ_EN
  localparam logic [7:0] RD_CMD     = 8'h6B;
  localparam logic [4:0] BYTE_RISES = 5'd2;
  localparam int         RX_W       = 4;
`else
  localparam logic [7:0] RD_CMD     = 8'h03;
  localparam logic [4:0] BYTE_RISES = 5'd8;
  localparam int         RX_W       = 7;
`endif

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] DUMMY = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;

`ifdef QSPI_QUAD_READ_EN
  localparam logic [2:0] AFTER_ADDR = DUMMY;
`else
  localparam logic [2:0] AFTER_ADDR = DATA;
`endif

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

  logic [2:0]      state;
  logic [DW-1:0]   div_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [4:0]      bcnt;
  logic [7:0]      byte_cnt;
  logic [7:0]      len_q;
  logic [30:0]     tx_sr;
  logic [RX_W-1:0] rx_sr;
  logic [7:0]      rx_next;
  logic            active, tick, rise, fall;

  assign bus.cmd_ready = (state == IDLE);
  assign active = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
  assign tick   = active && (div_cnt == DIV_LAST);
  assign rise   = tick && !sck;
  assign fall   = tick && sck;

`ifdef QSPI_QUAD_READ_EN
  assign rx_next = {rx_sr, io_in};
`else
  assign rx_next = {rx_sr, io_in[1]};
  logic unused_io;
  assign unused_io = ^{io_in[3:2], io_in[0]};
`endif

  // tx_sr holds the bits still to be shifted after the one currently on io0;
  // io0 is updated only in the sck-falling slot so the device sees stable data on rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      hold_cnt     <= '0;
      bcnt         <= '0;
      byte_cnt     <= '0;
      len_q        <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      sck          <= 1'b0;
      cs_n         <= 1'b1;
      io_out       <= 4'b0000;
      io_oe        <= 4'b0000;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      if (active) div_cnt <= tick ? '0 : div_cnt + DW'(1);

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state    <= CMD;
            cs_n     <= 1'b0;
            bus.busy <= 1'b1;
            len_q    <= bus.cmd_len;
            tx_sr    <= {RD_CMD[6:0], bus.cmd_addr};
            io_out   <= {3'b000, RD_CMD[7]};
            io_oe    <= 4'b0001;
            byte_cnt <= '0;
            bcnt     <= '0;
            div_cnt  <= '0;
          end
        end

        CMD, ADDR: begin
          if (rise) begin
            sck  <= 1'b1;
            bcnt <= bcnt + 5'd1;
          end
          if (fall) begin
            sck    <= 1'b0;
            io_out <= {3'b000, tx_sr[30]};
            tx_sr  <= {tx_sr[29:0], 1'b0};
            if (state == CMD && bcnt == 5'd8) begin
              state <= ADDR;
              bcnt  <= '0;
            end else if (state == ADDR && bcnt == 5'd24) begin
              state  <= AFTER_ADDR;
              bcnt   <= '0;
              io_out <= 4'b0000;
              io_oe  <= 4'b0000;
            end
          end
        end

        DUMMY: begin
          if (rise) begin
            sck  <= 1'b1;
            bcnt <= bcnt + 5'd1;
          end
          if (fall) begin
            sck <= 1'b0;
            if (bcnt == 5'd8) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
        end

        DATA: begin
          if (rise) begin
            sck   <= 1'b1;
            rx_sr <= rx_next[RX_W-1:0];
            bcnt  <= bcnt + 5'd1;
            if (bcnt == BYTE_RISES - 5'd1) begin
              bus.rd_valid <= 1'b1;
              bus.rd_data  <= rx_next;
            end
          end
          if (fall) begin
            sck <= 1'b0;
            if (bcnt == BYTE_RISES) begin
              bcnt <= '0;
              // Last byte: deselect in the same slot sck falls, so no partial sck cycle.
              if (byte_cnt == len_q) begin
                state    <= HOLD;
                cs_n     <= 1'b1;
                hold_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Bench for qspi_flash_ctrl: behavioural flash model on the pins plus a byte scoreboard.
// Honours QSPI_QUAD_READ_EN the same way the design does.
module tb_qspi_flash_ctrl;
  localparam int CLK_DIV = 2;
  localparam int CS_HOLD = 4;
  localparam int SCK_CLKS = 2 * CLK_DIV;
`ifdef QSPI_QUAD_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h6B;
  localparam int PRE = 40;
  localparam int BYTE_CYC = 2;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int PRE = 32;
  localparam int BYTE_CYC = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck, cs_n;
  logic [3:0] io_out, io_oe;
  logic [3:0] io_in = 4'b0000;

  qspi_flash_ctrl_if bus();

  qspi_flash_ctrl #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sck(sck), .cs_n(cs_n), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 clk = ~clk;

  // Flash model: 256-byte array aliased over the 24-bit space.
  logic [7:0]  mem [256];
  int          rises = 0;
  int          cs_falls = 0;
  logic [31:0] hdr = '0;

  always @(negedge cs_n) begin
    rises = 0;
    hdr = '0;
    cs_falls++;
  end

  always @(posedge sck) if (!cs_n) begin
    if (rises < 32) hdr = {hdr[30:0], io_out[0]};
    rises++;
  end

  always @(negedge sck) begin : dev_drive
    int k, idx;
    logic [7:0] b;
    logic bt;
    if (!cs_n && rises >= PRE) begin
      k = rises - PRE;
      idx = (int'(hdr[7:0]) + k / BYTE_CYC) % 256;
      b = mem[idx];
`ifdef QSPI_QUAD_READ_EN
      io_in = (k % 2 == 0) ? b[7:4] : b[3:0];
`else
      bt = b[7 - (k % 8)];
      io_in = {1'b1, 1'b0, bt, ~bt};
`endif
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [7:0] l, input int exp_rises);
    int cyc, n, cs_low, last_v, gap_bad, oe_bad;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_len = l;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_timeout", cyc < 20000, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    n = 0; cs_low = 0; last_v = -1; gap_bad = 0; oe_bad = 0; cyc = 0;
    while (bus.busy && cyc < 20000) begin
      if (!cs_n) begin
        cs_low++;
        if (rises < 32) begin
          if (io_oe !== 4'b0001) oe_bad++;
        end else if (!sck && io_oe !== 4'b0000) oe_bad++;
      end
      if (bus.rd_valid) begin
        chk("rd_data", bus.rd_data, mem[(int'(a[7:0]) + n) % 256]);
        if (last_v >= 0 && cyc - last_v != BYTE_CYC * SCK_CLKS) gap_bad++;
        last_v = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("txn_timeout", cyc < 20000, 1);
    chk("byte_count", n, int'(l) + 1);
    chk("sck_rises", rises, exp_rises);
    chk("header", hdr, {EXP_CMD, a});
    chk("cs_low_window", (cs_low >= exp_rises * SCK_CLKS) && (cs_low <= exp_rises * SCK_CLKS + SCK_CLKS), 1);
    chk("rd_spacing", gap_bad, 0);
    chk("oe_pattern", oe_bad, 0);
    chk("ready_after", bus.cmd_ready, 1);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    int          rises;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int cyc, accepts, high_run, gap_rec, falls0;
    bit seen_low;
    logic [7:0] rl;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    vecs[0] = '{24'h000000, 8'd0,   PRE + BYTE_CYC * 1};
    vecs[1] = '{24'h000010, 8'd3,   PRE + BYTE_CYC * 4};
    vecs[2] = '{24'hFFFFFE, 8'd3,   PRE + BYTE_CYC * 4};
    vecs[3] = '{24'h123456, 8'd1,   PRE + BYTE_CYC * 2};
    vecs[4] = '{24'hABCDEF, 8'd255, PRE + BYTE_CYC * 256};

    #23;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_io", {io_oe, io_out}, 0);
    chk("rst_rd", {bus.rd_valid, bus.rd_data}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i].addr, vecs[i].len, vecs[i].rises);

    // Reset in the middle of the address phase.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 24'h555555; bus.cmd_len = 8'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_addr_phase", (rises > 8) && (rises < 32), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sck", sck, 0);
    chk("midrst_oe", io_oe, 0);
    chk("midrst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.cmd_ready, 1);

    // Randomized transactions.
    for (int i = 0; i < 6; i++) begin
      rl = 8'($urandom_range(0, 20));
      run_txn(24'($urandom), rl, PRE + BYTE_CYC * (int'(rl) + 1));
    end

    // Back-to-back with cmd_valid held high.
    falls0 = cs_falls;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 24'h000020; bus.cmd_len = 8'd0;
    accepts = 0; high_run = 0; gap_rec = -1; seen_low = 0; cyc = 0;
    while ((accepts < 2 || bus.busy || bus.cmd_valid) && cyc < 3000) begin
      if (accepts == 2) bus.cmd_valid = 1'b0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        accepts++;
        chk("b2b_busy_at_accept", bus.busy, 0);
      end
      if (cs_n) high_run++;
      else begin
        if (seen_low && high_run > 0) gap_rec = high_run;
        seen_low = 1;
        high_run = 0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_timeout", cyc < 3000, 1);
    chk("b2b_accepts", accepts, 2);
    chk("b2b_cs_falls", cs_falls - falls0, 2);
    chk("b2b_cs_gap", gap_rec >= CS_HOLD, 1);

    // Request pulsed while busy must be dropped.
    falls0 = cs_falls;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 24'h000030; bus.cmd_len = 8'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 24'h000099; bus.cmd_len = 8'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("ignore_timeout", cyc < 3000, 1);
    repeat (100) @(negedge clk);
    chk("ignore_cs_falls", cs_falls - falls0, 1);
    chk("ignore_header", hdr, {EXP_CMD, 24'h000030});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
